// File: rtl/l1_dram_bridge_pkg.sv
// Shared definitions for the L1-to-DRAM beat bridge: state encodings and debug switch.
package l1_dram_bridge_pkg;

    localparam logic [2:0] BR_STATE_IDLE    = 3'd0;
    localparam logic [2:0] BR_STATE_WBURST  = 3'd1;
    localparam logic [2:0] BR_STATE_RBURST  = 3'd2;
    localparam logic [2:0] BR_STATE_ACK     = 3'd3;
    localparam logic [2:0] BR_STATE_RELEASE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = BR_STATE_IDLE,
        S_WBURST  = BR_STATE_WBURST,
        S_RBURST  = BR_STATE_RBURST,
        S_ACK     = BR_STATE_ACK,
        S_RELEASE = BR_STATE_RELEASE
    } br_state_e;

    // Enables internal protocol sanity assertions; elaborates away when 0.
    localparam bit DEBUG = 1'b0;

endpackage

// File: rtl/l1_dram_bridge_beat_unpack.sv
// Line register with per-beat write-slice mux and read-slice insert.
module l1_dram_beat_unpack #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 32,
    parameter int IW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] load_line,
    input  logic              ins_en,
    input  logic [IW-1:0]     ins_idx,
    input  logic [BEAT_W-1:0] ins_beat,
    input  logic [IW-1:0]     rd_idx,
    output logic [BEAT_W-1:0] rd_beat,
    output logic [LINE_W-1:0] line_nxt
);

    logic [LINE_W-1:0] line_q, line_d;

    always_comb begin
        line_d = line_q;
        if (load) begin
            line_d = load_line;
        end else if (ins_en) begin
            line_d[int'(ins_idx)*BEAT_W +: BEAT_W] = ins_beat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign rd_beat  = line_q[int'(rd_idx)*BEAT_W +: BEAT_W];
    // The top registers the completed read line from here so it lands with the ack.
    assign line_nxt = line_d;

endmodule

// File: rtl/l1_dram_bridge.sv
// Splits L1 line requests into address/data beats on the external bus and reassembles reads.
//   state   | meaning
//   IDLE    | waiting for dram_cs; captures address, line and direction
//   WBURST  | issuing NBEAT write beats, one per grant
//   RBURST  | issuing read beats and collecting rvalid beats into the line
//   ACK     | dram_ack high for this single cycle
//   RELEASE | waiting for dram_cs low so a held request is not replayed
module l1_dram_bridge
    import l1_dram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dram_cs,
    input  logic              dram_we,
    input  logic [ADDR_W-1:0] dram_addr,
    input  logic [LINE_W-1:0] dram_wdata,
    output logic [LINE_W-1:0] dram_rdata,
    output logic              dram_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    localparam int NBEAT      = LINE_W / BEAT_W;
    localparam int CW         = $clog2(NBEAT) + 1;
    localparam int IW         = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int OFF_W      = $clog2(LINE_W / 8);
    localparam int BEAT_BYTES = BEAT_W / 8;

    br_state_e         state_q, state_d;
    logic [CW-1:0]     issue_q, issue_d;
    logic [CW-1:0]     ret_q, ret_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              cap;
    logic              ins_en;
    logic [BEAT_W-1:0] wr_beat;
    logic [LINE_W-1:0] line_nxt;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^dram_addr[OFF_W-1:0];

    l1_dram_beat_unpack #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .IW     (IW)
    ) u_unpack (
        .clk       (clk),
        .rst       (rst),
        .load      (cap),
        .load_line (dram_wdata),
        .ins_en    (ins_en),
        .ins_idx   (ret_q[IW-1:0]),
        .ins_beat  (mem_rdata),
        .rd_idx    (issue_q[IW-1:0]),
        .rd_beat   (wr_beat),
        .line_nxt  (line_nxt)
    );

    // Bus outputs are decoded from registered state only, so reset forces them low at once.
    assign mem_req   = (state_q == S_WBURST) ||
                       ((state_q == S_RBURST) && (issue_q < CW'(NBEAT)));
    assign mem_we    = (state_q == S_WBURST);
    assign mem_addr  = mem_req ? (base_q + ADDR_W'(issue_q) * ADDR_W'(BEAT_BYTES)) : '0;
    assign mem_wdata = mem_we ? wr_beat : '0;
    assign dram_ack   = ack_q;
    assign dram_rdata = rdata_q;

    always_comb begin
        state_d = state_q;
        issue_d = issue_q;
        ret_d   = ret_q;
        base_d  = base_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        cap     = 1'b0;
        ins_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dram_cs) begin
                    cap     = 1'b1;
                    base_d  = {dram_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    issue_d = '0;
                    ret_d   = '0;
                    state_d = dram_we ? S_WBURST : S_RBURST;
                end
            end
            S_WBURST: begin
                if (mem_gnt) begin
                    issue_d = issue_q + CW'(1);
                    if (issue_q == CW'(NBEAT - 1)) begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                    end
                end
            end
            S_RBURST: begin
                if (mem_req && mem_gnt) begin
                    issue_d = issue_q + CW'(1);
                end
                if (mem_rvalid && (ret_q < CW'(NBEAT))) begin
                    ins_en = 1'b1;
                    ret_d  = ret_q + CW'(1);
                    if (ret_q == CW'(NBEAT - 1)) begin
                        rdata_d = line_nxt;
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                    end
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!dram_cs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            issue_q <= '0;
            ret_q   <= '0;
            base_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            ret_q   <= ret_d;
            base_q  <= base_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    if (DEBUG) begin : g_debug
        always_ff @(posedge clk) begin
            if (!rst) begin
                assert (!(dram_ack && mem_req));
            end
        end
    end

endmodule

// File: tb/tb_l1_dram_bridge.sv
// Self-checking bench for l1_dram_bridge: memory-model responder plus directed and random line transfers.
module tb_l1_dram_bridge;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 32;
    localparam int NBEAT  = LINE_W / BEAT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              dram_cs, dram_we;
    logic [ADDR_W-1:0] dram_addr;
    logic [LINE_W-1:0] dram_wdata, dram_rdata;
    logic              dram_ack;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BEAT_W-1:0] mem_wdata, mem_rdata;
    logic              mem_gnt, mem_rvalid;

    l1_dram_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .dram_cs    (dram_cs),
        .dram_we    (dram_we),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .dram_ack   (dram_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic we; logic [31:0] data;} xfer_t;
    typedef struct {int due; logic [31:0] data;} rv_t;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int gnt_mode = 0;
    int rlat = 1;
    int pc = 0;
    int rv_sent = 0;
    int ack_cnt = 0;
    int ack_cyc = 0;
    int stable_err = 0;
    bit pend = 0;
    bit req_drop_seen = 0;
    logic [31:0]  pend_addr, pend_data;
    logic [255:0] ack_rdata;
    logic [255:0] last_read_line = '0;
    xfer_t xq[$];
    rv_t   rq[$];
    logic [31:0] mem_model [bit [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5EED_0000;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // External memory: grant policy per mode, reads answered in order after rlat cycles.
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            pc++;
            case (gnt_mode)
                0:       mem_gnt = 1'b1;
                1:       mem_gnt = (pc % 3 == 0);
                default: mem_gnt = 1'($urandom_range(0, 1));
            endcase
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rq[0].data;
                void'(rq.pop_front());
                rv_sent++;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
        end
    end

    // Bus observer, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            pend = 0;
        end else begin
            if (dram_ack) begin
                ack_cnt++;
                ack_cyc   = cyc;
                ack_rdata = dram_rdata;
            end
            if (mem_req) begin
                if (pend && (mem_addr !== pend_addr || mem_wdata !== pend_data)) stable_err++;
                pend      = !mem_gnt;
                pend_addr = mem_addr;
                pend_data = mem_wdata;
                if (mem_gnt) begin
                    xq.push_back('{mem_addr, mem_we, mem_wdata});
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    else        rq.push_back('{cyc + rlat, mem_rd(mem_addr)});
                end
            end else begin
                pend = 0;
                if (rq.size() > 0 && !dram_ack) req_drop_seen = 1;
            end
        end
    end

    task automatic run_txn(input string tag, input bit we, input logic [31:0] addr,
                           input logic [255:0] wdata, input int hold, input int exp_lat);
        logic [31:0]  base;
        logic [255:0] exp_line;
        int start, n_hold;
        base = addr & ~32'h1F;
        for (int i = 0; i < NBEAT; i++)
            exp_line[i*32 +: 32] = we ? wdata[i*32 +: 32] : mem_rd(base + 32'(4*i));
        xq.delete();
        ack_cnt = 0;
        req_drop_seen = 0;
        dram_cs = 1'b1; dram_we = we; dram_addr = addr; dram_wdata = wdata;
        start = cyc;
        for (int k = 0; k < 300 && ack_cnt == 0; k++) begin
            @(posedge clk); #1;
        end
        check({tag, "/ack_seen"}, ack_cnt, 1);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
        end
        n_hold = xq.size();
        dram_cs = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check({tag, "/ack_count"}, ack_cnt, 1);
        check({tag, "/beats"}, n_hold, NBEAT);
        check({tag, "/beats_after_release"}, xq.size(), NBEAT);
        for (int i = 0; i < NBEAT && i < xq.size(); i++) begin
            check($sformatf("%s/addr%0d", tag, i), xq[i].addr, base + 32'(4*i));
            check($sformatf("%s/we%0d", tag, i), xq[i].we, we);
            if (we) check($sformatf("%s/wdata%0d", tag, i), xq[i].data, wdata[i*32 +: 32]);
        end
        if (!we) begin
            check({tag, "/rdata"}, ack_rdata, exp_line);
            last_read_line = exp_line;
        end else begin
            check({tag, "/rdata_kept"}, dram_rdata, last_read_line);
        end
        if (exp_lat > 0) check({tag, "/latency"}, ack_cyc - start, exp_lat);
        check({tag, "/stable"}, stable_err, 0);
    endtask

    initial begin
        logic [255:0] w;
        dram_cs = 1'b0; dram_we = 1'b0; dram_addr = '0; dram_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst/mem_req", mem_req, 0);
        check("rst/mem_we", mem_we, 0);
        check("rst/mem_addr", mem_addr, 0);
        check("rst/mem_wdata", mem_wdata, 0);
        check("rst/dram_ack", dram_ack, 0);
        check("rst/dram_rdata", dram_rdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        gnt_mode = 0; rlat = 1;
        for (int i = 0; i < NBEAT; i++) w[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        run_txn("wr_basic", 1'b1, 32'h1234_5678, w, 0, NBEAT + 1);

        rlat = 2;
        for (int i = 0; i < NBEAT; i++) mem_model[32'h0000_4000 + 32'(4*i)] = 32'hB0 + 32'(i);
        run_txn("rd_basic", 1'b0, 32'h0000_4004, '0, 0, NBEAT + 3);
        check("rd_basic/req_drop", req_drop_seen, 1);

        rlat = 1;
        run_txn("rd_back", 1'b0, 32'h1234_5660, '0, 0, NBEAT + 2);

        gnt_mode = 1;
        for (int i = 0; i < NBEAT; i++) w[i*32 +: 32] = $urandom;
        run_txn("wr_bp", 1'b1, 32'h0000_8000, w, 0, 0);

        gnt_mode = 0;
        for (int i = 0; i < NBEAT; i++) w[i*32 +: 32] = $urandom;
        run_txn("wr_hold", 1'b1, 32'h0000_9000, w, 5, NBEAT + 1);
        run_txn("rd_after_hold", 1'b0, 32'h0000_9010, '0, 0, NBEAT + 2);

        for (int i = 0; i < NBEAT; i++) w[i*32 +: 32] = 32'hC000_0000 + 32'(i);
        run_txn("wr_wrap", 1'b1, 32'hFFFF_FFE0, w, 0, NBEAT + 1);

        // Reset while the fourth read beat is on the bus.
        rlat = 1; rv_sent = 0; ack_cnt = 0;
        dram_cs = 1'b1; dram_we = 1'b0; dram_addr = 32'h0000_4000;
        for (int k = 0; k < 100 && rv_sent < 4; k++) begin
            @(posedge clk); #2;
        end
        check("rst_mid/reached", rv_sent, 4);
        rst = 1'b1;
        #1;
        check("rst_mid/mem_req", mem_req, 0);
        check("rst_mid/mem_addr", mem_addr, 0);
        check("rst_mid/mem_we", mem_we, 0);
        check("rst_mid/dram_ack", dram_ack, 0);
        check("rst_mid/dram_rdata", dram_rdata, 0);
        dram_cs = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        last_read_line = '0;
        for (int k = 0; k < 50 && rq.size() > 0; k++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid/no_ack", ack_cnt, 0);
        check("rst_mid/idle_req", mem_req, 0);
        run_txn("rd_post_rst", 1'b0, 32'h0000_4000, '0, 0, NBEAT + 2);

        gnt_mode = 2;
        for (int t = 0; t < 12; t++) begin
            logic [31:0] a;
            a = 32'h8000_0000 + 32'($urandom_range(0, 3) * 32) + 32'($urandom_range(0, 31));
            rlat = $urandom_range(1, 4);
            for (int i = 0; i < NBEAT; i++) w[i*32 +: 32] = $urandom;
            run_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), a, w, $urandom_range(0, 2), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
